// File: rtl/dp_mem_responder.sv
// Responder for the datapath memory interface: arbitrates instruction fetches and
// data accesses onto a single-port word RAM, returning one-cycle ihit/dhit pulses.
module dp_mem_responder (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  input  logic        dmemREN,
  input  logic        dmemWEN,
  input  logic [31:0] dmemaddr,
  input  logic [31:0] dmemstore,
  input  logic        halt,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] imemload,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        flushed,
  output logic        ram_err,
  output logic [31:0] icount,
  output logic [31:0] dcount
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;
  localparam logic [SW-1:0] RAM_ACCESS = SW'(2);
  localparam logic [SW-1:0] RAM_ERROR  = SW'(3);
  localparam logic [DW-1:0] WORD_MASK  = ~DW'(3);

  typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_e;

  state_e          state_q, state_d;
  logic            ihit_q, ihit_d, dhit_q, dhit_d;
  logic [DW-1:0]   imemload_q, imemload_d, dmemload_q, dmemload_d;
  logic            ram_ren_q, ram_ren_d, ram_wen_q, ram_wen_d;
  logic [DW-1:0]   ramaddr_q, ramaddr_d, ramstore_q, ramstore_d;
  logic            flushed_q, flushed_d, ram_err_q, ram_err_d;
  logic            halted_q, halted_d;
  logic [DW-1:0]   icount_q, icount_d, dcount_q, dcount_d;
  logic            dreq;

  assign dreq = dmemREN | dmemWEN;

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    ram_ren_d  = ram_ren_q;
    ram_wen_d  = ram_wen_q;
    ramaddr_d  = ramaddr_q;
    ramstore_d = ramstore_q;
    ram_err_d  = ram_err_q;
    halted_d   = halted_q | halt;
    icount_d   = icount_q;
    dcount_d   = dcount_q;

    unique case (state_q)
      IDLE: begin
        // Data has priority; a simultaneous read+write is serviced as a write
        if (dreq) begin
          state_d    = DACC;
          ram_wen_d  = dmemWEN;
          ram_ren_d  = ~dmemWEN;
          ramaddr_d  = dmemaddr & WORD_MASK;
          ramstore_d = dmemstore;
        end else if (imemREN && !halted_d) begin
          state_d   = IACC;
          ram_ren_d = 1'b1;
          ram_wen_d = 1'b0;
          ramaddr_d = imemaddr & WORD_MASK;
        end
      end
      DACC, IACC: begin
        if (ramstate == RAM_ACCESS) begin
          state_d   = RESP;
          ram_ren_d = 1'b0;
          ram_wen_d = 1'b0;
          if (state_q == IACC) begin
            imemload_d = ramload;
            ihit_d     = 1'b1;
            icount_d   = icount_q + DW'(1);
          end else begin
            if (ram_ren_q) dmemload_d = ramload;
            dhit_d   = 1'b1;
            dcount_d = dcount_q + DW'(1);
          end
        end else if (ramstate == RAM_ERROR) begin
          ram_err_d = 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    flushed_d = halted_d && (state_d == IDLE) && !dreq;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
      ram_ren_q  <= 1'b0;
      ram_wen_q  <= 1'b0;
      ramaddr_q  <= '0;
      ramstore_q <= '0;
      flushed_q  <= 1'b0;
      ram_err_q  <= 1'b0;
      halted_q   <= 1'b0;
      icount_q   <= '0;
      dcount_q   <= '0;
    end else begin
      state_q    <= state_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
      ram_ren_q  <= ram_ren_d;
      ram_wen_q  <= ram_wen_d;
      ramaddr_q  <= ramaddr_d;
      ramstore_q <= ramstore_d;
      flushed_q  <= flushed_d;
      ram_err_q  <= ram_err_d;
      halted_q   <= halted_d;
      icount_q   <= icount_d;
      dcount_q   <= dcount_d;
    end
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;
  assign ramREN   = ram_ren_q;
  assign ramWEN   = ram_wen_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;
  assign flushed  = flushed_q;
  assign ram_err  = ram_err_q;
  assign icount   = icount_q;
  assign dcount   = dcount_q;

endmodule

// File: tb/tb_dp_mem_responder.sv
// Transaction-level bench for dp_mem_responder: the bench plays the RAM and the
// datapath, and predicts hits, loads, counters and flags from a word-memory model.
module tb_dp_mem_responder;

  localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;
  localparam int K_FETCH = 0, K_LOAD = 1, K_STORE = 2;

  logic        CLK = 1'b0, nRST;
  logic        imemREN, dmemREN, dmemWEN, halt;
  logic [31:0] imemaddr, dmemaddr, dmemstore, ramload;
  logic [1:0]  ramstate;
  logic        ihit, dhit, ramREN, ramWEN, flushed, ram_err;
  logic [31:0] imemload, dmemload, ramaddr, ramstore, icount, dcount;

  dp_mem_responder dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .halt(halt), .ihit(ihit), .dhit(dhit), .imemload(imemload), .dmemload(dmemload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .flushed(flushed), .ram_err(ram_err),
    .icount(icount), .dcount(dcount)
  );

  always #5 CLK = ~CLK;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model state
  logic [31:0] mem [logic [29:0]];
  logic [31:0] exp_imem = '0, exp_dmem = '0, exp_icnt = '0, exp_dcnt = '0;
  bit          exp_err = 1'b0, exp_halted = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete access; latency is 2 + busy + error cycles after the sampling edge
  task automatic do_txn(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input int nbusy, input int nerr, input bit halt_mid);
    logic [31:0] waddr;
    logic [31:0] rval;
    waddr = addr & 32'hFFFF_FFFC;
    if (kind == K_FETCH) begin
      imemREN = 1'b1; imemaddr = addr;
    end else begin
      dmemaddr = addr;
      dmemWEN  = (kind == K_STORE);
      dmemREN  = (kind == K_STORE) ? 1'($urandom_range(0, 1)) : 1'b1;
      dmemstore = wdata;
    end
    ramstate = R_FREE;
    tick();
    // Inputs outside IDLE must be ignored; the latched request drives the RAM
    if (kind == K_FETCH) imemaddr = $urandom;
    else begin dmemaddr = $urandom; dmemstore = $urandom; end
    rval = mem.exists(waddr[31:2]) ? mem[waddr[31:2]] : $urandom;
    for (int c = 0; c < nbusy + nerr + 1; c++) begin
      chk("ihit_wait", 32'(ihit), 32'd0);
      chk("dhit_wait", 32'(dhit), 32'd0);
      chk("ramREN", 32'(ramREN), 32'(kind != K_STORE));
      chk("ramWEN", 32'(ramWEN), 32'(kind == K_STORE));
      chk("ramaddr", ramaddr, waddr);
      if (kind == K_STORE) chk("ramstore", ramstore, wdata);
      chk("ram_err_wait", 32'(ram_err), 32'(exp_err));
      if (c < nbusy) begin
        ramstate = R_BUSY; ramload = $urandom;
      end else if (c < nbusy + nerr) begin
        ramstate = R_ERROR; ramload = $urandom; exp_err = 1'b1;
      end else begin
        ramstate = R_ACCESS;
        ramload  = (kind == K_STORE) ? $urandom : rval;
      end
      if (halt_mid && c == 0) begin halt = 1'b1; exp_halted = 1'b1; end
      tick();
    end
    case (kind)
      K_FETCH: begin exp_imem = rval; exp_icnt++; mem[waddr[31:2]] = rval; end
      K_LOAD:  begin exp_dmem = rval; exp_dcnt++; mem[waddr[31:2]] = rval; end
      default: begin exp_dcnt++; mem[waddr[31:2]] = wdata; end
    endcase
    chk("ihit", 32'(ihit), 32'(kind == K_FETCH));
    chk("dhit", 32'(dhit), 32'(kind != K_FETCH));
    chk("ramREN_resp", 32'(ramREN), 32'd0);
    chk("ramWEN_resp", 32'(ramWEN), 32'd0);
    chk("imemload", imemload, exp_imem);
    chk("dmemload", dmemload, exp_dmem);
    chk("icount", icount, exp_icnt);
    chk("dcount", dcount, exp_dcnt);
    chk("ram_err", 32'(ram_err), 32'(exp_err));
    if (kind == K_FETCH) imemREN = 1'b0;
    else begin dmemREN = 1'b0; dmemWEN = 1'b0; end
    ramstate = R_FREE;
    ramload  = $urandom;
    tick();
    chk("ihit_idle", 32'(ihit), 32'd0);
    chk("dhit_idle", 32'(dhit), 32'd0);
    chk("ramREN_idle", 32'(ramREN), 32'd0);
    chk("ramWEN_idle", 32'(ramWEN), 32'd0);
    chk("flushed_idle", 32'(flushed), 32'(exp_halted));
    chk("imemload_hold", imemload, exp_imem);
    chk("dmemload_hold", dmemload, exp_dmem);
  endtask

  initial begin
    int kind;
    nRST = 1'b0; imemREN = 0; dmemREN = 0; dmemWEN = 0; halt = 0;
    imemaddr = '0; dmemaddr = '0; dmemstore = '0; ramload = '0; ramstate = R_FREE;
    #3;
    chk("rst_ihit", 32'(ihit), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_icount", icount, 32'd0);
    chk("rst_flushed", 32'(flushed), 32'd0);
    tick();
    nRST = 1'b1;
    tick();
    chk("idle_ramREN", 32'(ramREN), 32'd0);

    // Directed fetch: two BUSY cycles, hit four cycles after the sampling edge
    mem[30'h11] = 32'h2002_0001;
    do_txn(K_FETCH, 32'h0000_0046, '0, 2, 0, 1'b0);

    // Contention: data first, one IDLE cycle, then the fetch
    imemREN = 1'b1; imemaddr = 32'h0000_0080;
    do_txn(K_LOAD, 32'h0000_0104, '0, 1, 0, 1'b0);
    do_txn(K_FETCH, 32'h0000_0080, '0, 0, 0, 1'b0);

    // Store with immediate ACCESS leaves dmemload untouched
    do_txn(K_STORE, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 1'b0);
    do_txn(K_LOAD, 32'h0000_0102, '0, 0, 0, 1'b0);

    // Error then ACCESS: sticky flag, same address re-issued
    do_txn(K_LOAD, 32'h0000_0208, '0, 0, 1, 1'b0);

    // Randomized traffic over a small address window so loads revisit stores
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      do_txn(kind, 32'($urandom_range(0, 63)), $urandom,
             $urandom_range(0, 3), ($urandom_range(0, 5) == 0) ? 1 : 0, 1'b0);
    end

    // Halt raised during a fetch: fetch completes, later fetches ignored
    do_txn(K_FETCH, 32'h0000_0300, '0, 2, 0, 1'b1);
    imemREN = 1'b1; imemaddr = 32'h0000_0304;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("halt_ramREN", 32'(ramREN), 32'd0);
      chk("halt_ihit", 32'(ihit), 32'd0);
      chk("halt_flushed", 32'(flushed), 32'd1);
    end
    do_txn(K_LOAD, 32'h0000_0100, '0, 1, 0, 1'b0);
    do_txn(K_STORE, 32'h0000_0010, 32'h1234_5678, 0, 0, 1'b0);
    imemREN = 1'b0;

    // Asynchronous reset in the middle of a data access
    dmemREN = 1'b1; dmemaddr = 32'h0000_0020;
    tick();
    chk("pre_rst_ramREN", 32'(ramREN), 32'd1);
    #2 nRST = 1'b0; halt = 1'b0; dmemREN = 1'b0;
    #1;
    chk("arst_ramREN", 32'(ramREN), 32'd0);
    chk("arst_ramaddr", ramaddr, 32'd0);
    chk("arst_ram_err", 32'(ram_err), 32'd0);
    chk("arst_icount", icount, 32'd0);
    chk("arst_dcount", dcount, 32'd0);
    chk("arst_dmemload", dmemload, 32'd0);
    chk("arst_imemload", imemload, 32'd0);
    chk("arst_dhit", 32'(dhit), 32'd0);
    exp_imem = '0; exp_dmem = '0; exp_icnt = '0; exp_dcnt = '0;
    exp_err = 1'b0; exp_halted = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    chk("post_rst_flushed", 32'(flushed), 32'd0);
    chk("post_rst_dhit", 32'(dhit), 32'd0);
    do_txn(K_FETCH, 32'h0000_0044, '0, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_mem_responder.md
# dp_mem_responder

Responder end of the datapath–cache interface: services instruction fetches and data loads/stores issued by the single-cycle datapath and returns `ihit`/`dhit` with load data. It sits between the datapath and a single-port word RAM, arbitrates the two request streams onto that port, and tracks halt and access counts. It replaces the pass-through cache stub in the CPU top level.

## Interface
- No parameters.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: asynchronous active-low reset.
- `imemREN` in 1: instruction read request, held until `ihit`.
- `imemaddr` in 32: instruction byte address.
- `dmemREN` in 1: data read request, held until `dhit`.
- `dmemWEN` in 1: data write request, held until `dhit`.
- `dmemaddr` in 32: data byte address.
- `dmemstore` in 32: store data.
- `halt` in 1: registered halt from the datapath.
- `ihit` out 1: one-cycle pulse, instruction fetch complete.
- `dhit` out 1: one-cycle pulse, data access complete.
- `imemload` out 32: fetched instruction, valid while `ihit`.
- `dmemload` out 32: load data, valid while `dhit`.
- `ramREN` out 1, `ramWEN` out 1: RAM read/write strobes.
- `ramaddr` out 32: word-aligned RAM address.
- `ramstore` out 32: RAM write data.
- `ramload` in 32: RAM read data, valid when `ramstate` = ACCESS.
- `ramstate` in 2: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `flushed` out 1: halt seen and no access outstanding.
- `ram_err` out 1: sticky, set on any ERROR response.
- `icount` out 32, `dcount` out 32: completed fetch / data-access counters.

## Operation
- FSM states: IDLE, DACC, IACC, RESP.
- IDLE: if `dmemREN|dmemWEN` → DACC, latching address, store data, and write flag. Else if `imemREN` and not halted → IACC, latching address. Else stay. Data wins any simultaneous request.
- `dmemWEN` and `dmemREN` both high: treated as write.
- DACC/IACC: drive `ramREN` or `ramWEN`, `ramaddr` = {latched[31:2], 2'b00}, `ramstore` = latched store.
  - `ramstate` FREE/BUSY: hold.
  - ACCESS: capture `ramload` (reads), → RESP.
  - ERROR: set `ram_err`, stay and re-issue the same access.
- RESP: assert exactly one of `ihit`/`dhit` according to the serviced stream; load register drives `imemload` or `dmemload`. Increment the matching counter (32-bit, wraps). → IDLE.
- `imemload`/`dmemload` hold their last captured value outside RESP. Writes do not alter `dmemload`.
- Halt: `halt` high sets a sticky halted flag. No new fetches are started; an in-flight fetch completes; data accesses are still serviced.
- `flushed` = halted & state IDLE & no data request pending.
- RAM strobes are low in IDLE and RESP.

## Timing
- Reset (async): state IDLE. `ihit`, `dhit`, `ramREN`, `ramWEN`, `flushed`, `ram_err`, halted all 0. `imemload`, `dmemload`, `ramaddr`, `ramstore`, `icount`, `dcount` all 0.
- Request sampled in IDLE at edge N. Strobes are high from cycle N+1. If ACCESS is seen in cycle N+1+k (k BUSY cycles), the hit is in cycle N+2+k. Minimum request-to-hit latency: 2 cycles.
- Requestor drops its request on the edge ending the hit cycle. IDLE then resamples, so back-to-back accesses cost one IDLE cycle each.
- Request inputs are ignored outside IDLE; latched values drive the RAM.
- Reset mid-access: abort immediately, strobes low, no hit, counters cleared.
- `ram_err` clears only on reset.

## Test plan
- Reset: `nRST`=0 mid-DACC → all outputs 0 asynchronously; after release, state IDLE, `flushed`=0.
- Fetch: `imemREN`=1, `imemaddr`=0x0000_0046, `ramstate` BUSY×2 then ACCESS with `ramload`=0x2002_0001. Required: `ramaddr`=0x44, `ihit`=1 for exactly one cycle, 4 cycles after the sampling edge, `imemload`=0x2002_0001, `icount`=1.
- Contention: `imemREN`=`dmemREN`=1 in the same cycle. Required: data serviced first (`dhit`), then fetch (`ihit`), with one IDLE cycle between.
- Store: `dmemWEN`=1, `dmemaddr`=0x100, `dmemstore`=0xDEAD_BEEF, immediate ACCESS. Required: `ramWEN`=1, `ramstore`=0xDEAD_BEEF, `dhit` pulse, `dmemload` unchanged, `dcount` increments.
- Error: first response ERROR, then ACCESS. Required: `ram_err`=1, access re-issued with the same address, single `hit` afterwards.
- Halt: `halt`=1 during IACC. Required: fetch completes, later `imemREN` is ignored, `flushed`=1 in IDLE, and a subsequent `dmemREN` is still serviced.
